// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM divider.
// Defaults reproduce the legacy fixed divider: period 606 with a 50% duty cycle.
package pwm_pkg;

  localparam int PWM_CNT_W      = 28;
  localparam int PWM_NUM_CH     = 4;
  localparam int PWM_DEF_PERIOD = 606;
  localparam int PWM_DEF_HIGH   = 303;

  typedef logic [PWM_CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t                  period;
    cnt_t [PWM_NUM_CH-1:0] high;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: registered compare of the shared counter against this channel's high count.
module pwm_cmp_ch #(
  parameter int CNT_W = 28
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] high,
  output logic             pwm
);

  // high=0 never matches and high>=period always matches, giving constant low/high.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= run && (cnt < high);
    end
  end

endmodule

// File: rtl/pwm_div_gen.sv
// Shared period counter driving NUM_CH duty-cycle outputs. A valid/ready config port
// loads shadow registers, which become active only at a period boundary.
module pwm_div_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W      = PWM_CNT_W,
  parameter int NUM_CH     = PWM_NUM_CH,
  parameter int DEF_PERIOD = PWM_DEF_PERIOD,
  parameter int DEF_HIGH   = PWM_DEF_HIGH
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    tick,
  output logic [CNT_W-1:0]        cnt_out,
  output logic                    cfg_pending
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] shadow_period_reg;
  logic             pending_reg;
  logic             tick_reg;

  logic period_ok;
  logic last;
  logic run;
  logic accept;
  logic apply;

  // P-1 is only meaningful for P>=1, so the wrap compare is qualified by period_ok.
  assign period_ok = (period_reg != '0);
  assign last      = period_ok && (cnt_reg == period_reg - CNT_ONE);
  assign run       = en && period_ok;
  assign accept    = cfg_valid && !pending_reg;
  // A stopped counter has no boundary to wait for, so the shadow applies immediately.
  assign apply     = pending_reg && (!run || last);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_reg           <= '0;
      period_reg        <= CNT_W'(DEF_PERIOD);
      shadow_period_reg <= CNT_W'(DEF_PERIOD);
      pending_reg       <= 1'b0;
      tick_reg          <= 1'b0;
    end else begin
      tick_reg <= run && last;
      if (!run || last) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
      if (apply) begin
        period_reg  <= shadow_period_reg;
        pending_reg <= 1'b0;
      end else if (accept) begin
        shadow_period_reg <= cfg_period;
        pending_reg       <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] high_reg;
      logic [CNT_W-1:0] shadow_high_reg;

      always_ff @(posedge clk_in) begin
        if (rst) begin
          high_reg        <= CNT_W'(DEF_HIGH);
          shadow_high_reg <= CNT_W'(DEF_HIGH);
        end else if (apply) begin
          high_reg <= shadow_high_reg;
        end else if (accept) begin
          shadow_high_reg <= cfg_high[gi*CNT_W +: CNT_W];
        end
      end

      pwm_cmp_ch #(
        .CNT_W (CNT_W)
      ) u_cmp (
        .clk_in (clk_in),
        .rst    (rst),
        .run    (run),
        .cnt    (cnt_reg),
        .high   (high_reg),
        .pwm    (pwm_out[gi])
      );
    end
  endgenerate

  assign cfg_ready   = !pending_reg;
  assign cfg_pending = pending_reg;
  assign tick        = tick_reg;
  assign cnt_out     = cnt_reg;

endmodule
